// File: rtl/mod_msg_pad_pkg.sv
// Shared definitions for the message padder.
// Holds the padder state encoding, the padding byte, block geometry and the
// index of the two length words, plus a byte-lane placement helper.
package mod_msg_pad_pkg;

  typedef enum logic [1:0] {
    ST_DATA,
    ST_PAD,
    ST_LEN_HI,
    ST_LEN_LO
  } state_e;

  localparam logic [7:0] PAD_BYTE   = 8'h80;
  localparam int         BLK_WORDS  = 16;
  localparam logic [3:0] LEN_HI_IDX = 4'd14;
  localparam logic [3:0] LEN_LO_IDX = 4'd15;

  // Put byte b into lane k of a big-endian word (lane 0 = bits 31:24).
  function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [1:0] k);
    return {b, 24'h000000} >> {k, 3'b000};
  endfunction

endpackage

// File: rtl/mod_msg_pad.sv
// Message padder: packs a byte stream into big-endian 32-bit words and
// appends the 0x80 marker, zero fill and the 64-bit bit length so that the
// output is a whole number of 512-bit blocks.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/in_ready handshake for in_data (message byte) and in_last
//   out_valid/out_ready handshake for out_data (word W[out_idx])
//   out_idx          word index within the block, 0..15
//   out_blk_last     high when out_idx == 15
//   out_msg_last     high on the final (length low) word of a message
module mod_msg_pad #(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_blk_last,
  output logic        out_msg_last,
  input  logic        out_ready
);
  import mod_msg_pad_pkg::*;

  localparam int IDX_W = $clog2(BLK_WORDS);

  state_e           state_reg, state_next;
  logic [LEN_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic [31:0]      pack_reg, pack_next;
  logic             pad_mark_reg, pad_mark_next;
  logic             out_valid_reg, out_valid_next;
  logic [31:0]      out_data_reg, out_data_next;
  logic [IDX_W-1:0] out_idx_reg, out_idx_next;
  logic             out_msg_last_reg, out_msg_last_next;

  logic        accept;
  logic        consume;
  logic [1:0]  lane;
  logic [31:0] word;
  logic [63:0] bit_len;

  assign lane    = byte_cnt_reg[1:0];
  assign word    = pack_reg | place_byte(in_data, lane);
  assign bit_len = 64'(byte_cnt_reg) << 3;

  // Gated by rst_n so the input stays closed while reset is held.
  assign in_ready = rst_n && (state_reg == ST_DATA) && !out_valid_reg;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_reg && out_ready;

  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_idx      = out_idx_reg;
  assign out_blk_last = (out_idx_reg == LEN_LO_IDX);
  assign out_msg_last = out_msg_last_reg;

  always_comb begin
    state_next        = state_reg;
    byte_cnt_next     = byte_cnt_reg;
    pack_next         = pack_reg;
    pad_mark_next     = pad_mark_reg;
    out_valid_next    = out_valid_reg;
    out_data_next     = out_data_reg;
    out_idx_next      = out_idx_reg;
    out_msg_last_next = out_msg_last_reg;

    // accept and consume are mutually exclusive: in_ready needs !out_valid.
    if (accept) begin
      byte_cnt_next = byte_cnt_reg + LEN_W'(1);
      if (in_last) begin
        out_valid_next = 1'b1;
        pack_next      = 32'h0;
        state_next     = ST_PAD;
        if (lane == 2'd3) begin
          // Word is full: the 0x80 marker goes into the next word.
          out_data_next = word;
          pad_mark_next = 1'b1;
        end else begin
          // Lanes above the marker are already zero since pack_reg clears per word.
          out_data_next = word | place_byte(PAD_BYTE, lane + 2'd1);
          pad_mark_next = 1'b0;
        end
      end else if (lane == 2'd3) begin
        out_valid_next = 1'b1;
        out_data_next  = word;
        pack_next      = 32'h0;
      end else begin
        pack_next = word;
      end
    end

    if (consume) begin
      out_idx_next = out_idx_reg + 1'b1;
      unique case (state_reg)
        ST_DATA: out_valid_next = 1'b0;
        ST_PAD: begin
          if (pad_mark_reg) begin
            out_data_next = {PAD_BYTE, 24'h000000};
            pad_mark_next = 1'b0;
          end else if (out_idx_reg == LEN_HI_IDX - 4'd1) begin
            state_next    = ST_LEN_HI;
            out_data_next = bit_len[63:32];
          end else begin
            // Also covers the wrap into a second block when the marker
            // landed at index 14 or 15.
            out_data_next = 32'h0;
          end
        end
        ST_LEN_HI: begin
          state_next        = ST_LEN_LO;
          out_data_next     = bit_len[31:0];
          out_msg_last_next = 1'b1;
        end
        ST_LEN_LO: begin
          state_next        = ST_DATA;
          out_valid_next    = 1'b0;
          out_msg_last_next = 1'b0;
          byte_cnt_next     = '0;
          out_idx_next      = '0;
        end
        default: state_next = ST_DATA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_DATA;
      byte_cnt_reg     <= '0;
      pack_reg         <= 32'h0;
      pad_mark_reg     <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_data_reg     <= 32'h0;
      out_idx_reg      <= '0;
      out_msg_last_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      byte_cnt_reg     <= byte_cnt_next;
      pack_reg         <= pack_next;
      pad_mark_reg     <= pad_mark_next;
      out_valid_reg    <= out_valid_next;
      out_data_reg     <= out_data_next;
      out_idx_reg      <= out_idx_next;
      out_msg_last_reg <= out_msg_last_next;
    end
  end

endmodule

// File: tb/tb_mod_msg_pad.sv
// Testbench for mod_msg_pad: scoreboard of expected words filled by a
// byte-level padding model, checked by an independent output monitor.
module tb_mod_msg_pad;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        blk_last;
    logic        msg_last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_blk_last;
  logic        out_msg_last;
  logic        out_ready = 1'b0;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: stall idx 0/15
  int    stall_cnt = 0;
  logic [3:0] last_idx = 4'd0;
  bit    gaps = 1'b0;

  mod_msg_pad #(.LEN_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_blk_last(out_blk_last), .out_msg_last(out_msg_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (out_idx != last_idx) stall_cnt = 0;
          last_idx = out_idx;
          if (out_valid && (out_idx == 4'd0 || out_idx == 4'd15) && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: compares every consumed word against the scoreboard and checks
  // that a stalled word holds steady.
  word_t held;
  logic  held_stall = 1'b0;
  always @(negedge clk) begin
    word_t cur;
    word_t exp_w;
    cur.data = out_data;
    cur.idx = out_idx;
    cur.blk_last = out_blk_last;
    cur.msg_last = out_msg_last;
    if (rst_n && out_valid) begin
      if (held_stall) begin
        n_checks++;
        if (cur !== held) begin
          n_fail++;
          $display("FAIL hold_stable: got %h/%0d/%b/%b required %h/%0d/%b/%b",
                   cur.data, cur.idx, cur.blk_last, cur.msg_last,
                   held.data, held.idx, held.blk_last, held.msg_last);
        end
      end
      held = cur;
      held_stall = !out_ready;
      if (out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got %h idx %0d, required none", cur.data, cur.idx);
        end else begin
          exp_w = exp_q.pop_front();
          if (cur !== exp_w) begin
            n_fail++;
            $display("FAIL word: got %h idx %0d blk %b msg %b required %h idx %0d blk %b msg %b",
                     cur.data, cur.idx, cur.blk_last, cur.msg_last,
                     exp_w.data, exp_w.idx, exp_w.blk_last, exp_w.msg_last);
          end else begin
            $display("word ok %h idx %0d blk %b msg %b", cur.data, cur.idx, cur.blk_last, cur.msg_last);
          end
        end
      end
    end else begin
      held_stall = 1'b0;
    end
  end

  // Reference: pad the byte string the textbook way, then cut into words.
  function automatic void push_model(input byte_q_t m);
    byte_q_t     p;
    logic [63:0] bl;
    int          nw;
    word_t       w;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nw = p.size() / 4;
    for (int j = 0; j < nw; j++) begin
      w.data = {p[4*j], p[4*j+1], p[4*j+2], p[4*j+3]};
      w.idx = 4'(j % 16);
      w.blk_last = (j % 16 == 15);
      w.msg_last = (j == nw - 1);
      exp_q.push_back(w);
    end
  endfunction

  function automatic void push_word(input logic [31:0] d, input int idx, input logic ml);
    word_t w;
    w.data = d;
    w.idx = 4'(idx);
    w.blk_last = (idx == 15);
    w.msg_last = ml;
    exp_q.push_back(w);
  endfunction

  function automatic void push_abc_literal();
    push_word(32'h61626380, 0, 1'b0);
    for (int i = 1; i <= 14; i++) push_word(32'h00000000, i, 1'b0);
    push_word(32'h00000018, 15, 1'b1);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int   cnt;
    logic acc;
    in_valid = 1'b1;
    in_data = b;
    in_last = last;
    cnt = 0;
    acc = 1'b0;
    while (!acc && cnt < 2000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: byte %h not accepted, in_ready %b required 1", b, in_ready);
    end
    in_valid = 1'b0;
    in_data = 8'($urandom);
    in_last = 1'($urandom);
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_msg(input byte_q_t m);
    for (int i = 0; i < m.size(); i++) send_byte(m[i], i == m.size() - 1);
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || out_valid) && cnt < 5000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_flags", 64'({out_blk_last, out_msg_last}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    byte_q_t msg;
    string   s;
    int      len;

    repeat (2) @(posedge clk);
    reset_pulse();

    // "abc" against the literal expected block
    msg = {8'h61, 8'h62, 8'h63};
    push_abc_literal();
    send_msg(msg);
    wait_drain();

    // "Hello world!"
    s = "Hello world!";
    msg = {};
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    push_model(msg);
    send_msg(msg);
    wait_drain();

    // 55 and 56 bytes of 'a': one block vs spill into a second block
    for (int n = 55; n <= 56; n++) begin
      msg = {};
      for (int i = 0; i < n; i++) msg.push_back(8'h61);
      push_model(msg);
      send_msg(msg);
      wait_drain();
    end

    // "abc" with stalls on idx 0 and idx 15
    ready_mode = 2;
    msg = {8'h61, 8'h62, 8'h63};
    push_abc_literal();
    send_msg(msg);
    wait_drain();
    ready_mode = 0;

    // Reset after two bytes of "Hello", then "abc"
    send_byte(8'h48, 1'b0);
    send_byte(8'h65, 1'b0);
    reset_pulse();
    msg = {8'h61, 8'h62, 8'h63};
    push_abc_literal();
    send_msg(msg);
    wait_drain();

    // Random messages with random backpressure and input gaps; the first
    // batch sweeps lengths around the one/two-block boundary.
    ready_mode = 1;
    gaps = 1'b1;
    for (int m = 0; m < 24; m++) begin
      len = (m < 14) ? 50 + m : int'($urandom_range(1, 130));
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      push_model(msg);
      send_msg(msg);
      wait_drain();
    end

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
